// File: rtl/axi_lite_cfg_writer.sv
// AXI-Lite configuration master: writes REG_NUM payload words to consecutive
// engine registers, then waits for engine completion by interrupt or polling.
module axi_lite_cfg_writer #(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    PAYLOAD_WIDTH = 1024,
   parameter int                    REG_NUM       = 15,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int                    ADDR_STRIDE   = 4,
   parameter int                    DONE_MODE     = 0,
   parameter logic [ADDR_WIDTH-1:0] POLL_ADDR     = 'h80,
   parameter int                    POLL_BIT      = 0,
   parameter int                    POLL_GAP      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     engine_start,
   input  logic [PAYLOAD_WIDTH-1:0] payload,
   input  logic                     engine_interrupt,
   output logic                     engine_busy,
   output logic                     engine_done,
   output logic                     engine_error,
   output logic                     m_axi_awvalid,
   input  logic                     m_axi_awready,
   output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
   output logic [2:0]               m_axi_awprot,
   output logic                     m_axi_wvalid,
   input  logic                     m_axi_wready,
   output logic [DATA_WIDTH-1:0]    m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]  m_axi_wstrb,
   input  logic                     m_axi_bvalid,
   output logic                     m_axi_bready,
   input  logic [1:0]               m_axi_bresp,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
   output logic [2:0]               m_axi_arprot,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready,
   input  logic [DATA_WIDTH-1:0]    m_axi_rdata,
   input  logic [1:0]               m_axi_rresp
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR       = 3'd1;
   localparam logic [2:0] ST_WRESP    = 3'd2;
   localparam logic [2:0] ST_WAIT_IRQ = 3'd3;
   localparam logic [2:0] ST_POLL_AR  = 3'd4;
   localparam logic [2:0] ST_POLL_R   = 3'd5;
   localparam logic [2:0] ST_POLL_GAP = 3'd6;
   localparam logic [2:0] ST_DONE     = 3'd7;

   localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);
   localparam logic [4:0]            LAST_IDX = 5'(REG_NUM - 1);
   localparam logic [7:0]            GAP_LAST = 8'(POLL_GAP - 1);

   logic [2:0]               state;
   logic [4:0]               idx;
   logic [7:0]               gap_cnt;
   logic                     irq_latch;
   logic [PAYLOAD_WIDTH-1:0] payload_q;
   logic                     aw_ok;
   logic                     w_ok;
   logic                     unused_rdata;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = '1;
   assign m_axi_araddr = POLL_ADDR;
   // The current word always sits in the low slice of the shifting payload copy.
   assign m_axi_wdata  = payload_q[DATA_WIDTH-1:0];
   assign unused_rdata = ^m_axi_rdata;

   // A channel is complete once its valid has dropped or it handshakes now.
   assign aw_ok = !m_axi_awvalid || m_axi_awready;
   assign w_ok  = !m_axi_wvalid  || m_axi_wready;

   // NOTE: every register here uses <= so all next-state terms read the
   // pre-edge values; the payload copy is reset too because wdata must read 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         idx           <= '0;
         gap_cnt       <= '0;
         irq_latch     <= 1'b0;
         payload_q     <= '0;
         m_axi_awaddr  <= BASE_ADDR;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         engine_busy   <= 1'b0;
         engine_done   <= 1'b0;
         engine_error  <= 1'b0;
      end else begin
         if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
         if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
         if (engine_busy && engine_interrupt) irq_latch <= 1'b1;

         case (state)
            ST_IDLE, ST_DONE: begin
               if (engine_start) begin
                  payload_q     <= payload;
                  idx           <= '0;
                  irq_latch     <= 1'b0;
                  m_axi_awaddr  <= BASE_ADDR;
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  engine_busy   <= 1'b1;
                  engine_done   <= 1'b0;
                  engine_error  <= 1'b0;
                  state         <= ST_WR;
               end
            end
            ST_WR: begin
               if (aw_ok && w_ok) begin
                  m_axi_bready <= 1'b1;
                  state        <= ST_WRESP;
               end
            end
            ST_WRESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  if (m_axi_bresp != 2'b00) begin
                     engine_error <= 1'b1;
                     engine_busy  <= 1'b0;
                     engine_done  <= 1'b1;
                     state        <= ST_DONE;
                  end else if (idx == LAST_IDX) begin
                     if (DONE_MODE == 1) begin
                        m_axi_arvalid <= 1'b1;
                        state         <= ST_POLL_AR;
                     end else begin
                        state <= ST_WAIT_IRQ;
                     end
                  end else begin
                     idx           <= idx + 5'd1;
                     m_axi_awaddr  <= m_axi_awaddr + STRIDE;
                     payload_q     <= payload_q >> DATA_WIDTH;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= ST_WR;
                  end
               end
            end
            ST_WAIT_IRQ: begin
               if (irq_latch || engine_interrupt) begin
                  engine_busy <= 1'b0;
                  engine_done <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_POLL_AR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= ST_POLL_R;
               end
            end
            ST_POLL_R: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  if (m_axi_rresp != 2'b00 || m_axi_rdata[POLL_BIT]) begin
                     engine_error <= (m_axi_rresp != 2'b00);
                     engine_busy  <= 1'b0;
                     engine_done  <= 1'b1;
                     state        <= ST_DONE;
                  end else begin
                     gap_cnt <= '0;
                     state   <= ST_POLL_GAP;
                  end
               end
            end
            ST_POLL_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  m_axi_arvalid <= 1'b1;
                  state         <= ST_POLL_AR;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_cfg_writer.sv
// Directed-plus-random bench: a write-logging AXI-Lite slave for the interrupt
// instance and a polling slave for a second, DONE_MODE=1 instance.
`timescale 1ns/1ps
module tb_axi_lite_cfg_writer;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int PW  = 1024;
   localparam int RN  = 15;
   localparam int PPW = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance A: interrupt completion, default parameters
   logic a_start, a_irq, a_busy, a_done, a_error;
   logic [PW-1:0] a_payload;
   logic a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
   logic a_arvalid, a_arready, a_rvalid, a_rready;
   logic [AW-1:0] a_awaddr, a_araddr;
   logic [2:0] a_awprot, a_arprot;
   logic [DW-1:0] a_wdata, a_rdata;
   logic [DW/8-1:0] a_wstrb;
   logic [1:0] a_bresp, a_rresp;

   axi_lite_cfg_writer dut (
      .clk(clk), .rst(rst), .engine_start(a_start), .payload(a_payload),
      .engine_interrupt(a_irq), .engine_busy(a_busy), .engine_done(a_done),
      .engine_error(a_error),
      .m_axi_awvalid(a_awvalid), .m_axi_awready(a_awready), .m_axi_awaddr(a_awaddr),
      .m_axi_awprot(a_awprot), .m_axi_wvalid(a_wvalid), .m_axi_wready(a_wready),
      .m_axi_wdata(a_wdata), .m_axi_wstrb(a_wstrb), .m_axi_bvalid(a_bvalid),
      .m_axi_bready(a_bready), .m_axi_bresp(a_bresp), .m_axi_arvalid(a_arvalid),
      .m_axi_arready(a_arready), .m_axi_araddr(a_araddr), .m_axi_arprot(a_arprot),
      .m_axi_rvalid(a_rvalid), .m_axi_rready(a_rready), .m_axi_rdata(a_rdata),
      .m_axi_rresp(a_rresp)
   );

   // instance P: polled completion
   logic p_start, p_irq, p_busy, p_done, p_error;
   logic [PPW-1:0] p_payload;
   logic p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
   logic p_arvalid, p_arready, p_rvalid, p_rready;
   logic [AW-1:0] p_awaddr, p_araddr;
   logic [2:0] p_awprot, p_arprot;
   logic [DW-1:0] p_wdata, p_rdata;
   logic [DW/8-1:0] p_wstrb;
   logic [1:0] p_bresp, p_rresp;

   axi_lite_cfg_writer #(
      .PAYLOAD_WIDTH(PPW), .REG_NUM(2), .DONE_MODE(1), .POLL_GAP(4)
   ) dut_poll (
      .clk(clk), .rst(rst), .engine_start(p_start), .payload(p_payload),
      .engine_interrupt(p_irq), .engine_busy(p_busy), .engine_done(p_done),
      .engine_error(p_error),
      .m_axi_awvalid(p_awvalid), .m_axi_awready(p_awready), .m_axi_awaddr(p_awaddr),
      .m_axi_awprot(p_awprot), .m_axi_wvalid(p_wvalid), .m_axi_wready(p_wready),
      .m_axi_wdata(p_wdata), .m_axi_wstrb(p_wstrb), .m_axi_bvalid(p_bvalid),
      .m_axi_bready(p_bready), .m_axi_bresp(p_bresp), .m_axi_arvalid(p_arvalid),
      .m_axi_arready(p_arready), .m_axi_araddr(p_araddr), .m_axi_arprot(p_arprot),
      .m_axi_rvalid(p_rvalid), .m_axi_rready(p_rready), .m_axi_rdata(p_rdata),
      .m_axi_rresp(p_rresp)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- slave A: write logger with optional backpressure ----------------
   int a_aw_max = 0, a_w_max = 0, a_err_reg = -1;
   int a_aw_wait, a_w_wait;
   bit a_aw_armed, a_w_armed, a_aw_seen, a_w_seen, a_b_pend, a_aw_waiting, a_w_waiting;
   logic [AW-1:0] a_awaddr_hold;
   logic [DW-1:0] a_wdata_hold;
   logic [AW-1:0] aw_log[$];
   logic [DW-1:0] w_log[$];
   int b_cnt = 0, b_last_edge = 0, stab_viol = 0, ovl_viol = 0;

   always @(negedge clk) begin
      if (rst) begin
         a_awready = 0; a_wready = 0; a_bvalid = 0; a_bresp = 0;
         a_aw_armed = 0; a_w_armed = 0; a_aw_seen = 0; a_w_seen = 0;
         a_b_pend = 0; a_aw_waiting = 0; a_w_waiting = 0;
      end else begin
         if (a_b_pend) begin
            a_bvalid = 0; a_bresp = 0; a_b_pend = 0;
         end
         if (a_aw_seen && a_w_seen) begin
            a_bvalid = 1;
            a_bresp = (aw_log.size() - 1 == a_err_reg) ? 2'b10 : 2'b00;
            a_aw_seen = 0; a_w_seen = 0;
         end
         if (a_awvalid) begin
            if (a_aw_waiting && a_awaddr !== a_awaddr_hold) stab_viol++;
            if (!a_aw_armed) begin
               a_aw_armed = 1; a_aw_wait = $urandom_range(a_aw_max, 0);
            end
            if (a_aw_wait > 0) begin
               a_aw_wait--; a_awready = 0; a_aw_waiting = 1; a_awaddr_hold = a_awaddr;
            end else begin
               a_awready = 1; a_aw_armed = 0; a_aw_waiting = 0;
               if (aw_log.size() != b_cnt) ovl_viol++;
               aw_log.push_back(a_awaddr); a_aw_seen = 1;
            end
         end else begin
            if (a_aw_waiting) stab_viol++;
            a_aw_waiting = 0; a_awready = 0;
         end
         if (a_wvalid) begin
            if (a_w_waiting && a_wdata !== a_wdata_hold) stab_viol++;
            if (!a_w_armed) begin
               a_w_armed = 1; a_w_wait = $urandom_range(a_w_max, 0);
            end
            if (a_w_wait > 0) begin
               a_w_wait--; a_wready = 0; a_w_waiting = 1; a_wdata_hold = a_wdata;
            end else begin
               a_wready = 1; a_w_armed = 0; a_w_waiting = 0;
               if (w_log.size() != b_cnt) ovl_viol++;
               w_log.push_back(a_wdata); a_w_seen = 1;
            end
         end else begin
            if (a_w_waiting) stab_viol++;
            a_w_waiting = 0; a_wready = 0;
         end
         if (a_bvalid && a_bready) begin
            a_b_pend = 1; b_cnt++; b_last_edge = cyc + 1;
         end
      end
   end

   // ---------------- slave P: zero-wait writes, status reads ----------------
   bit p_ar_pend, p_r_pend;
   logic [AW-1:0] ar_addr_log[$];
   int ar_edge_log[$];
   int r_edge_log[$];

   always @(negedge clk) begin
      if (rst) begin
         p_bvalid = 0; p_arready = 0; p_rvalid = 0; p_rdata = 0;
         p_ar_pend = 0; p_r_pend = 0;
      end else begin
         p_bvalid = p_bready;
         if (p_r_pend) begin
            p_rvalid = 0; p_r_pend = 0;
         end
         if (p_ar_pend) begin
            p_rvalid = 1;
            p_rdata = $urandom;
            p_rdata[0] = (r_edge_log.size() + 1 == 3);
            p_ar_pend = 0;
         end
         p_arready = p_arvalid;
         if (p_arvalid) begin
            ar_addr_log.push_back(p_araddr); ar_edge_log.push_back(cyc + 1); p_ar_pend = 1;
         end
         if (p_rvalid && p_rready) begin
            r_edge_log.push_back(cyc + 1); p_r_pend = 1;
         end
      end
   end

   // ---------------- sequence ----------------
   int s_edge;
   logic [PW-1:0] exp_payload;

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic wait_edge(input int n);
      while (cyc < n) tick();
   endtask

   task automatic clear_log();
      aw_log.delete(); w_log.delete();
      b_cnt = 0; stab_viol = 0; ovl_viol = 0;
   endtask

   task automatic start_a(input logic [PW-1:0] p);
      a_payload = p; a_start = 1; s_edge = cyc + 1;
      tick();
      a_start = 0;
   endtask

   task automatic wait_b(input int n, input int limit, input string tag);
      int k = 0;
      while (b_cnt < n && k < limit) begin
         tick(); k++;
      end
      check(tag, b_cnt, n);
   endtask

   // Reference: register k goes to BASE + k*STRIDE and carries payload word k.
   task automatic check_writes(input string tag, input int n, input logic [PW-1:0] p);
      check({tag, " aw count"}, aw_log.size(), n);
      check({tag, " w count"}, w_log.size(), n);
      for (int k = 0; k < n && k < aw_log.size() && k < w_log.size(); k++) begin
         check($sformatf("%s addr[%0d]", tag, k), aw_log[k], k * 4);
         check($sformatf("%s data[%0d]", tag, k), w_log[k], p[k*DW +: DW]);
      end
   endtask

   function automatic logic [PW-1:0] rand_payload();
      logic [PW-1:0] p;
      for (int k = 0; k < PW / 32; k++) p[k*32 +: 32] = $urandom;
      return p;
   endfunction

   initial begin
      rst = 1; a_start = 0; a_irq = 0; a_payload = '0;
      a_arready = 0; a_rvalid = 0; a_rdata = '0; a_rresp = 2'b00;
      p_start = 0; p_irq = 0; p_payload = '0;
      p_awready = 1; p_wready = 1; p_bresp = 2'b00; p_rresp = 2'b00;
      repeat (3) tick();

      // reset state
      check("rst busy/done/error", {a_busy, a_done, a_error}, 3'b000);
      check("rst valids/readies", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready}, 5'b0);
      check("rst awaddr", a_awaddr, 32'h0);
      check("rst araddr", a_araddr, 32'h80);
      check("rst wdata", a_wdata, 32'h0);
      check("rst prot/strb", {a_awprot, a_arprot, a_wstrb}, {3'b000, 3'b000, 4'hf});
      check("rst poll busy", p_busy, 1'b0);
      rst = 0;
      tick();

      // 1: zero-wait slave, word k = k+1, interrupt in cycle 40
      exp_payload = rand_payload();
      for (int k = 0; k < RN; k++) exp_payload[k*DW +: DW] = k + 1;
      clear_log();
      start_a(exp_payload);
      check("t1 busy cycle1", a_busy, 1'b1);
      check("t1 valids cycle1", {a_awvalid, a_wvalid}, 2'b11);
      wait_edge(s_edge + 39);
      check("t1 done before irq", a_done, 1'b0);
      a_irq = 1;
      tick();
      a_irq = 0;
      check("t1 done cycle41", {a_done, a_busy, a_error}, 3'b100);
      check("t1 last B edge", b_last_edge - s_edge, 2 * RN);
      check_writes("t1", RN, exp_payload);

      // 2: interrupt pulse while register 2 is being written
      exp_payload = rand_payload();
      clear_log();
      start_a(exp_payload);
      check("t1 start in DONE clears done", a_done, 1'b0);
      wait_edge(s_edge + 4);
      check("t2 writing reg2", a_awaddr, 32'h8);
      a_irq = 1;
      tick();
      a_irq = 0;
      wait_edge(s_edge + 30);
      check("t2 done after last B", a_done, 1'b0);
      tick();
      check("t2 done 1 cycle after B", a_done, 1'b1);
      check("t2 last B edge", b_last_edge - s_edge, 2 * RN);

      // 3: random backpressure plus an ignored start while busy
      exp_payload = rand_payload();
      clear_log();
      a_aw_max = 5; a_w_max = 5;
      start_a(exp_payload);
      repeat (6) tick();
      check("t3 busy mid-job", a_busy, 1'b1);
      a_payload = rand_payload(); a_start = 1;
      tick();
      a_start = 0;
      wait_b(RN, 600, "t3 B count");
      repeat (8) tick();
      check_writes("t3", RN, exp_payload);
      check("t3 valid stability", stab_viol, 0);
      check("t3 one outstanding", ovl_viol, 0);
      check("t3 waiting irq", {a_busy, a_done}, 2'b10);
      a_irq = 1;
      tick();
      a_irq = 0;
      check("t3 done", {a_done, a_error}, 2'b10);
      a_aw_max = 0; a_w_max = 0;

      // 4: SLVERR on register 3, interrupt latched earlier in that job
      exp_payload = rand_payload();
      clear_log();
      a_err_reg = 3;
      start_a(exp_payload);
      wait_edge(s_edge + 2);
      a_irq = 1;
      tick();
      a_irq = 0;
      wait_b(4, 100, "t4 B count");
      repeat (2) tick();
      check("t4 error/done/busy", {a_error, a_done, a_busy}, 3'b110);
      check_writes("t4", 4, exp_payload);
      repeat (20) tick();
      check("t4 no further AW", aw_log.size(), 4);
      a_err_reg = -1;

      // start coincident with interrupt in DONE: old latch and this pulse are discarded
      exp_payload = rand_payload();
      clear_log();
      a_irq = 1;
      start_a(exp_payload);
      a_irq = 0;
      check("t4b restart flags", {a_busy, a_done, a_error}, 3'b100);
      wait_edge(s_edge + 34);
      check("t4b no stale completion", a_done, 1'b0);
      a_irq = 1;
      tick();
      a_irq = 0;
      check("t4b done", a_done, 1'b1);
      check_writes("t4b", RN, exp_payload);

      // 5: reset during WRESP, then a clean job
      clear_log();
      start_a(rand_payload());
      wait_edge(s_edge + 7);
      check("t5 in WRESP", a_bready, 1'b1);
      rst = 1;
      #1;
      check("t5 rst flags", {a_busy, a_done, a_error}, 3'b000);
      check("t5 rst valids", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready}, 5'b0);
      check("t5 rst awaddr/wdata", {a_awaddr, a_wdata}, 64'h0);
      repeat (2) tick();
      rst = 0;
      tick();
      exp_payload = rand_payload();
      clear_log();
      start_a(exp_payload);
      wait_b(RN, 100, "t5 B count");
      tick();
      a_irq = 1;
      tick();
      a_irq = 0;
      check("t5 done", {a_done, a_error, a_busy}, 3'b100);
      check_writes("t5", RN, exp_payload);

      // 6: polled completion, status bit set on the 3rd read
      p_payload = {$urandom, $urandom};
      p_start = 1;
      tick();
      p_start = 0;
      begin
         int k = 0;
         while (r_edge_log.size() < 3 && k < 300) begin
            tick(); k++;
         end
      end
      check("t6 R count", r_edge_log.size(), 3);
      check("t6 not early", p_done, 1'b0);
      tick();
      check("t6 done after 3rd R", {p_done, p_busy, p_error}, 3'b100);
      repeat (20) tick();
      check("t6 AR count", ar_addr_log.size(), 3);
      for (int k = 0; k < 3 && k < ar_addr_log.size(); k++)
         check($sformatf("t6 araddr[%0d]", k), ar_addr_log[k], 32'h80);
      for (int k = 0; k < 2 && k + 1 < ar_edge_log.size() && k < r_edge_log.size(); k++)
         check($sformatf("t6 idle gap[%0d]>=4", k),
               (ar_edge_log[k+1] - r_edge_log[k] - 1) >= 4, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
